// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the pipeline hazard/forwarding control
//
// Purpose : FSM state and forwarding-select encodings, register address width,
//           counter saturation value and a register-match helper.
// Ports   : none (package).

package mips_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      RUN    = 2'b00,
      DRAIN  = 2'b01,
      HALTED = 2'b10
   } hz_state_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_t;

   // A producer matches a consumer only when it writes, targets a real
   // register (r0 is hardwired zero) and the addresses agree.
   function automatic logic reg_match(input logic wr,
                                      input logic [REG_ADDR_W-1:0] rd,
                                      input logic [REG_ADDR_W-1:0] rs);
      return wr && (rd != '0) && (rd == rs);
   endfunction

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - EX operand forwarding select
//
// Purpose : picks the source for each EX operand; MEM beats WB, r0 never forwards.
// Ports   : ex_rs, ex_rt          in  EX source registers
//           mem_rd, mem_reg_write in  MEM producer
//           wb_rd, wb_reg_write   in  WB producer
//           fwd_a, fwd_b          out 00 regfile, 01 MEM result, 10 WB result

module fwd_unit
   import mips_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] ex_rs,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  wb_reg_write,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b
);

   function automatic fwd_sel_t pick(input logic [REG_ADDR_W-1:0] src);
      if (reg_match(mem_reg_write, mem_rd, src))
         return FWD_MEM;
      else if (reg_match(wb_reg_write, wb_rd, src))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

   always_comb begin
      fwd_a = pick(ex_rs);
      fwd_b = pick(ex_rt);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard detection, halt drain FSM and stall/flush counters
//
// Purpose : drives PC/IF-ID enables and flushes from FSM state and pipeline
//           inputs; counts stall cycles and taken-branch flushes.
//           Optional macro FORWARDING_EN: load-use-only stalls plus fwd_unit
//           operand forwarding; default build stalls on any EX/MEM producer
//           and ties forwarding to the regfile.
// Ports   : clk, rst                         clock, sync active-high reset
//           id_rs/rt, id_uses_rs/rt, id_halt ID stage
//           ex_rs/rt/rd, ex_reg_write, ex_mem_read, ex_is_taken  EX stage
//           mem_rd, mem_reg_write, wb_rd, wb_reg_write, wb_halt  MEM/WB
//           pc_en, ifid_en, ifid_flush, idex_flush               pipeline control
//           fwd_a, fwd_b                     EX operand source select
//           halted, stall_cnt, flush_cnt     status

module hazard_ctrl
   import mips_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic                  id_halt,
   input  logic [REG_ADDR_W-1:0] ex_rs,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_reg_write,
   input  logic                  ex_mem_read,
   input  logic                  ex_is_taken,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  wb_reg_write,
   input  logic                  wb_halt,
   output logic                  pc_en,
   output logic                  ifid_en,
   output logic                  ifid_flush,
   output logic                  idex_flush,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic                  halted,
   output logic [31:0]           stall_cnt,
   output logic [31:0]           flush_cnt
);

   hz_state_t  state;
   logic       rs_hz;
   logic       rt_hz;
   logic       hazard;
   logic       taken_act;
   logic       stall_act;
   logic [1:0] fwd_a_sel;
   logic [1:0] fwd_b_sel;
   logic       unused_sink;

   // WB producers are never hazards: the regfile writes before it is read.
`ifdef FORWARDING_EN
   assign rs_hz = id_uses_rs && reg_match(ex_mem_read, ex_rd, id_rs);
   assign rt_hz = id_uses_rt && reg_match(ex_mem_read, ex_rd, id_rt);

   fwd_unit u_fwd (
      .ex_rs         (ex_rs),
      .ex_rt         (ex_rt),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .fwd_a         (fwd_a_sel),
      .fwd_b         (fwd_b_sel)
   );

   assign unused_sink = ex_reg_write;
`else
   assign rs_hz = id_uses_rs && (reg_match(ex_reg_write, ex_rd, id_rs) ||
                                 reg_match(mem_reg_write, mem_rd, id_rs));
   assign rt_hz = id_uses_rt && (reg_match(ex_reg_write, ex_rd, id_rt) ||
                                 reg_match(mem_reg_write, mem_rd, id_rt));
   assign fwd_a_sel = FWD_RF;
   assign fwd_b_sel = FWD_RF;

   assign unused_sink = ^{ex_rs, ex_rt, wb_rd, wb_reg_write, ex_mem_read};
`endif

   assign hazard    = rs_hz || rt_hz;
   // A taken branch overrides any stall, so it is acted on in RUN and DRAIN.
   assign taken_act = ex_is_taken && ((state == RUN) || (state == DRAIN));
   assign stall_act = (state == RUN) && hazard && !ex_is_taken;

   always_comb begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      fwd_a      = FWD_RF;
      fwd_b      = FWD_RF;
      if (rst) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else begin
         fwd_a = fwd_a_sel;
         fwd_b = fwd_b_sel;
         if (taken_act) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else begin
            case (state)
               RUN: begin
                  if (hazard) begin
                     idex_flush = 1'b1;
                  end else begin
                     pc_en   = 1'b1;
                     ifid_en = 1'b1;
                  end
               end
               DRAIN: begin
                  ifid_en    = 1'b1;
                  ifid_flush = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         halted    <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         case (state)
            RUN:
               // HALT is only honoured on a clean cycle (no branch, no stall).
               if (!ex_is_taken && !hazard && id_halt)
                  state <= DRAIN;
            DRAIN:
               if (wb_halt) begin
                  state  <= HALTED;
                  halted <= 1'b1;
               end
            HALTED:
               state <= HALTED;
            default:
               state <= RUN;
         endcase
         if (stall_act && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + 32'd1;
         if (taken_act && (flush_cnt != CNT_MAX))
            flush_cnt <= flush_cnt + 32'd1;
      end
   end

endmodule
